// File: rtl/pb_ctrl_if.sv
// Pushbutton controller signal bundle.
// master: the side that drives the raw button and rider_off (board/bench).
// slave : pb_ctrl itself.
interface pb_ctrl_if;
    logic PB;
    logic rider_off;
    logic pressed;
    logic short_pulse;
    logic long_pulse;
    logic pwr_up;
    logic steer_en;
    logic pb_stuck;

    modport master (
        output PB, rider_off,
        input  pressed, short_pulse, long_pulse, pwr_up, steer_en, pb_stuck
    );

    modport slave (
        input  PB, rider_off,
        output pressed, short_pulse, long_pulse, pwr_up, steer_en, pb_stuck
    );
endinterface

// File: rtl/pb_ctrl.sv
// pb_ctrl: Segway pushbutton controller.
// Synchronizes and debounces the active-low PB pin, classifies presses as
// short or long, and sequences pwr_up (long press) and steer_en (short press
// while powered up).
// Optional feature macro: PB_STUCK_DET_EN -- flags a button held for
// STUCK_CYC clocks, drops both enables and discards that press.
module pb_ctrl #(
    parameter int DEB_CYC   = 50000,
    parameter int LONG_CYC  = 50000000,
    parameter int STUCK_CYC = 500000000
) (
    input logic      clk,
    input logic      rst_n,
    pb_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEB_CYC);
    localparam int HW = $clog2(STUCK_CYC + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_CYC - 1);
`ifdef PB_STUCK_DET_EN
    localparam logic [HW-1:0] HOLD_STUCK = HW'(STUCK_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HOLD_STUCK;
`else
    localparam logic [HW-1:0] HOLD_MAX   = HOLD_LONG;
`endif

    typedef enum logic [2:0] {IDLE, DEB_P, HELD, LONG, DEB_R} state_t;

    state_t        state;
    logic          s1, s2;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic          kind_long;
    logic          pressed, short_pulse, long_pulse;
    logic          pwr_up, steer_en;
    logic          pwr_nxt;
    logic          stuck_hit;
`ifdef PB_STUCK_DET_EN
    logic          stuck;
`endif

    // Two-flop synchronizer; resets released so no phantom press out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= bus.PB;
            s2 <= s1;
        end
    end

    // Saturating next hold count. hold_cnt counts HELD cycles inclusively,
    // so the long press fires on the edge where the count reaches LONG_CYC-1.
    always_comb begin
        hold_nxt = hold_cnt;
        if (hold_cnt != HOLD_MAX)
            hold_nxt = hold_cnt + HW'(1);
    end

`ifdef PB_STUCK_DET_EN
    // Stuck detection fires once, on the edge the LONG hold reaches STUCK_CYC-1.
    assign stuck_hit = (state == LONG) && !s2 && !stuck && (hold_nxt == HOLD_STUCK);
`else
    assign stuck_hit = 1'b0;
`endif

    // Debounce / press-classification FSM with registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            kind_long   <= 1'b0;
            pressed     <= 1'b0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
`ifdef PB_STUCK_DET_EN
            stuck       <= 1'b0;
`endif
        end else begin
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s2) begin
                        state   <= DEB_P;
                        deb_cnt <= '0;
                    end
                end
                DEB_P: begin
                    if (s2) begin
                        state <= IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= HELD;
                        pressed  <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                HELD: begin
                    if (s2) begin
                        state     <= DEB_R;
                        kind_long <= 1'b0;
                        deb_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_nxt;
                        if (hold_nxt == HOLD_LONG) begin
                            state      <= LONG;
                            long_pulse <= 1'b1;
                        end
                    end
                end
                LONG: begin
                    if (s2) begin
                        state     <= DEB_R;
                        kind_long <= 1'b1;
                        deb_cnt   <= '0;
                    end
`ifdef PB_STUCK_DET_EN
                    else if (!stuck) begin
                        hold_cnt <= hold_nxt;
                        if (stuck_hit)
                            stuck <= 1'b1;
                    end
`endif
                end
                DEB_R: begin
                    // A bounce back to pressed resumes the press; hold_cnt stays frozen.
                    if (!s2) begin
                        state <= kind_long ? LONG : HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= IDLE;
                        pressed     <= 1'b0;
                        short_pulse <= !kind_long;
`ifdef PB_STUCK_DET_EN
                        stuck       <= 1'b0;
`endif
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // pwr_up toggles after a long_pulse cycle; a stuck button forces it off.
    assign pwr_nxt = stuck_hit ? 1'b0 : (pwr_up ^ long_pulse);

    // Enable sequencing: rider_off, then loss of power, then short-press toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_up   <= 1'b0;
            steer_en <= 1'b0;
        end else begin
            pwr_up <= pwr_nxt;
            if (bus.rider_off)
                steer_en <= 1'b0;
            else if (!pwr_up || !pwr_nxt)
                steer_en <= 1'b0;
            else if (short_pulse)
                steer_en <= ~steer_en;
        end
    end

    assign bus.pressed     = pressed;
    assign bus.short_pulse = short_pulse;
    assign bus.long_pulse  = long_pulse;
    assign bus.pwr_up      = pwr_up;
    assign bus.steer_en    = steer_en;
`ifdef PB_STUCK_DET_EN
    assign bus.pb_stuck    = stuck;
`else
    assign bus.pb_stuck    = 1'b0;
`endif
endmodule

// File: tb/tb_pb_ctrl.sv
// Directed bench for pb_ctrl with DEB_CYC=4, LONG_CYC=20, STUCK_CYC=40.
// Inputs change and outputs are sampled 1 time unit after each rising edge;
// "edge N" is the rising edge that first samples a new PB level.
module tb_pb_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    pb_ctrl_if bus ();

    pb_ctrl #(.DEB_CYC(4), .LONG_CYC(20), .STUCK_CYC(40)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int sh_cnt = 0, lg_cnt = 0, pr_cnt = 0, both_cnt = 0;
    int sh_cyc = 0, lg_cyc = 0;
    logic pr_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: counts pulses and pressed rises, remembers when they occur.
    always @(negedge clk) begin
        if (bus.short_pulse) begin sh_cnt++; sh_cyc = cyc; end
        if (bus.long_pulse)  begin lg_cnt++; lg_cyc = cyc; end
        if (bus.short_pulse && bus.long_pulse) both_cnt++;
        if (bus.pressed && !pr_prev) pr_cnt++;
        pr_prev = bus.pressed;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int n0, sh0, lg0, pr0;

    initial begin
        bus.PB = 1'b1;
        bus.rider_off = 1'b0;
        #2 rst_n = 1'b0;
        tick(3);
        // 1. reset state
        chk("rst_pressed", bus.pressed, 0);
        chk("rst_short", bus.short_pulse, 0);
        chk("rst_long", bus.long_pulse, 0);
        chk("rst_pwr", bus.pwr_up, 0);
        chk("rst_steer", bus.steer_en, 0);
        chk("rst_stuck", bus.pb_stuck, 0);
        rst_n = 1'b1;
        tick(100);
        chk("idle_short_cnt", sh_cnt, 0);
        chk("idle_long_cnt", lg_cnt, 0);
        chk("idle_pressed_cnt", pr_cnt, 0);

        // 2. 3-cycle glitch is rejected
        pr0 = pr_cnt; sh0 = sh_cnt; lg0 = lg_cnt;
        bus.PB = 1'b0; tick(3);
        bus.PB = 1'b1; tick(10);
        chk("glitch_pressed", pr_cnt - pr0, 0);
        chk("glitch_pulses", (sh_cnt - sh0) + (lg_cnt - lg0), 0);

        // 3. short press while powered down
        sh0 = sh_cnt;
        bus.PB = 1'b0;
        tick(6);
        chk("short_pressed_n5", bus.pressed, 0);
        tick(1);
        chk("short_pressed_n6", bus.pressed, 1);
        tick(3);
        bus.PB = 1'b1;
        tick(6);
        chk("short_pulse_r5", bus.short_pulse, 0);
        chk("short_still_pressed", bus.pressed, 1);
        tick(1);
        chk("short_pulse_r6", bus.short_pulse, 1);
        chk("short_released", bus.pressed, 0);
        tick(1);
        chk("short_pulse_width", bus.short_pulse, 0);
        chk("short_steer_off", bus.steer_en, 0);
        tick(3);
        chk("short_once", sh_cnt - sh0, 1);

        // 4. long press powers up
        sh0 = sh_cnt; lg0 = lg_cnt;
        bus.PB = 1'b0;
        tick(25);
        chk("long_n24", bus.long_pulse, 0);
        tick(1);
        chk("long_n25", bus.long_pulse, 1);
        chk("long_pwr_n25", bus.pwr_up, 0);
        tick(1);
        chk("long_n26", bus.long_pulse, 0);
        chk("long_pwr_n26", bus.pwr_up, 1);
        tick(3);
        bus.PB = 1'b1;
        tick(12);
        chk("long_once", lg_cnt - lg0, 1);
        chk("long_no_short", sh_cnt - sh0, 0);
        chk("long_pwr_hold", bus.pwr_up, 1);

        // short press with power up enables steering
        bus.PB = 1'b0; tick(10);
        bus.PB = 1'b1; tick(7);
        chk("steer_pulse", bus.short_pulse, 1);
        chk("steer_pre", bus.steer_en, 0);
        tick(1);
        chk("steer_on", bus.steer_en, 1);
        tick(5);

        // 5. rider_off for one cycle drops steering only
        bus.rider_off = 1'b1; tick(1);
        bus.rider_off = 1'b0;
        chk("rider_steer", bus.steer_en, 0);
        chk("rider_pwr", bus.pwr_up, 1);
        tick(3);
        chk("rider_steer_hold", bus.steer_en, 0);

        // re-enable steering, then long press drops both on one edge
        bus.PB = 1'b0; tick(10);
        bus.PB = 1'b1; tick(12);
        chk("steer_on2", bus.steer_en, 1);
        bus.PB = 1'b0;
        tick(26);
        chk("off_long_n25", bus.long_pulse, 1);
        chk("off_pwr_n25", bus.pwr_up, 1);
        chk("off_steer_n25", bus.steer_en, 1);
        tick(1);
        chk("off_pwr_n26", bus.pwr_up, 0);
        chk("off_steer_n26", bus.steer_en, 0);
        tick(3);
        bus.PB = 1'b1;
        tick(12);

        // 6. release bounce during HELD: no short, long still arrives later
        sh0 = sh_cnt; lg0 = lg_cnt;
        bus.PB = 1'b0;
        n0 = cyc + 1;
        tick(10);
        bus.PB = 1'b1; tick(2);
        bus.PB = 1'b0; tick(15);
        chk("bounce_no_early_long", lg_cnt - lg0, 0);
        tick(6);
        chk("bounce_long_once", lg_cnt - lg0, 1);
        chk("bounce_long_window", (lg_cyc > n0 + 26 && lg_cyc <= n0 + 32) ? 1 : 0, 1);
        bus.PB = 1'b1;
        tick(12);
        chk("bounce_no_short", sh_cnt - sh0, 0);
        chk("bounce_pwr", bus.pwr_up, 1);

        // extra long press to power down again
        bus.PB = 1'b0; tick(30);
        bus.PB = 1'b1; tick(12);
        chk("pwr_down_again", bus.pwr_up, 0);

        // 60-cycle hold: stuck detection when enabled, plain long press otherwise
        sh0 = sh_cnt; lg0 = lg_cnt;
        bus.PB = 1'b0;
        tick(31);
        chk("hold60_pwr_up", bus.pwr_up, 1);
        tick(29);
`ifdef PB_STUCK_DET_EN
        chk("hold60_stuck", bus.pb_stuck, 1);
        chk("hold60_pwr", bus.pwr_up, 0);
        chk("hold60_steer", bus.steer_en, 0);
`else
        chk("hold60_stuck", bus.pb_stuck, 0);
        chk("hold60_pwr", bus.pwr_up, 1);
`endif
        bus.PB = 1'b1;
        tick(12);
        chk("hold60_stuck_clr", bus.pb_stuck, 0);
        chk("hold60_no_short", sh_cnt - sh0, 0);
        chk("hold60_one_long", lg_cnt - lg0, 1);
        chk("hold60_released", bus.pressed, 0);

        chk("pulse_exclusive", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
